truth_table_sequencer: RTL and testbench

- Clocked controller that sweeps the input vectors of a small combinational circuit (the f-function exercises, N_IN inputs, one output) and samples the circuit output after a settle delay.
- Assembles the captured truth table and checks it against an expected table latched at start.
- Sits beside the combinational DUT: `dut_in` drives the circuit inputs and `dut_out` returns its output.
- Replaces hand-written stimulus loops with a reusable start/done-controlled checker.

---
 rtl/truth_table_sequencer_pkg.sv | 10 +
 rtl/truth_table_sequencer_if.sv | 14 +
 rtl/truth_table_sequencer_settle_cnt.sv | 19 +
 rtl/truth_table_sequencer.sv | 88 ++++++++
 tb/tb_truth_table_sequencer.sv | 120 ++++++++++++
 5 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// tt_seq_pkg: shared state encoding and settle-counter width for the truth table sequencer
package tt_seq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: control, golden table and circuit-side signals of the sequencer
interface truth_table_sequencer_if #(parameter int N_IN = 2);
  logic                  start;
  logic [2**N_IN-1:0]    expected;
  logic                  dut_out;
  logic [N_IN-1:0]       dut_in;
  logic                  busy;
  logic                  done;
  logic [2**N_IN-1:0]    tt;
  logic                  pass;
  logic [N_IN-1:0]       fail_idx;
  modport master (output start, expected, dut_out, input dut_in, busy, done, tt, pass, fail_idx);
  modport slave (input start, expected, dut_out, output dut_in, busy, done, tt, pass, fail_idx);
endinterface

// File: rtl/truth_table_sequencer_settle_cnt.sv
// tt_settle_cnt: settle-delay counter with clear, enable and terminal count at SETTLE-1
import tt_seq_pkg::*;
module tt_settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  // clear wins over enable so a new vector always starts counting from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CNT_W'(SETTLE - 1);
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all input vectors, captures and checks the truth table (TT_STOP_ON_MISMATCH_EN ends on first mismatch)
import tt_seq_pkg::*;
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sequencer_if.slave bus
);
  localparam int W = 2**N_IN;
  state_t           state;
  logic [W-1:0]     exp_q;
  logic [N_IN:0]    idx;
  logic             mis;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             clr;
  logic             en;
  logic             hit;
  logic             last;
  assign clr  = (state == IDLE && bus.start) || state == SAMPLE;
  assign en   = state == WAIT;
  assign hit  = bus.dut_out != exp_q[idx[N_IN-1:0]] && !mis;
  assign last = idx == (N_IN+1)'(W - 1);
  tt_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .cnt (cnt),
    .tc  (tc)
  );
  // sweep FSM with capture, first-mismatch tracking and registered status outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      exp_q        <= '0;
      idx          <= '0;
      mis          <= 1'b0;
      bus.dut_in   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.tt       <= '0;
      bus.pass     <= 1'b0;
      bus.fail_idx <= '0;
    end else begin
      bus.done <= state == FINISH;
      unique case (state)
        IDLE:
          if (bus.start) begin
            exp_q        <= bus.expected;
            bus.tt       <= '0;
            bus.fail_idx <= '0;
            bus.pass     <= 1'b0;
            mis          <= 1'b0;
            idx          <= '0;
            bus.dut_in   <= '0;
            bus.busy     <= 1'b1;
            state        <= WAIT;
          end
        WAIT:
          if (tc) state <= SAMPLE;
        SAMPLE: begin
          bus.tt[idx[N_IN-1:0]] <= bus.dut_out;
          if (hit) begin
            mis          <= 1'b1;
            bus.fail_idx <= idx[N_IN-1:0];
          end
`ifdef TT_STOP_ON_MISMATCH_EN
          if (last || hit) state <= FINISH;
`else
          if (last) state <= FINISH;
`endif
          else begin
            idx        <= idx + 1'b1;
            bus.dut_in <= N_IN'(idx + 1'b1);
            state      <= WAIT;
          end
        end
        FINISH: begin
          bus.pass <= !mis;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: randomized sweeps of two sequencers (SETTLE 1 and 3) against a table-level model
module tb_truth_table_sequencer;
`ifdef TT_STOP_ON_MISMATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         sel = 0;
  logic       start_r = 1'b0;
  logic [3:0] exp_r = '0;
  logic [3:0] fn_r = '0;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  truth_table_sequencer_if #(.N_IN(2)) b0 ();
  truth_table_sequencer_if #(.N_IN(2)) b1 ();
  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  assign b0.start    = start_r && sel == 0;
  assign b1.start    = start_r && sel == 1;
  assign b0.expected = exp_r;
  assign b1.expected = exp_r;
  assign b0.dut_out  = fn_r[b0.dut_in];
  assign b1.dut_out  = fn_r[b1.dut_in];
  logic [1:0] o_in, o_fi;
  logic [3:0] o_tt;
  logic       o_done, o_busy, o_pass;
  assign o_in   = sel == 1 ? b1.dut_in : b0.dut_in;
  assign o_fi   = sel == 1 ? b1.fail_idx : b0.fail_idx;
  assign o_tt   = sel == 1 ? b1.tt : b0.tt;
  assign o_done = sel == 1 ? b1.done : b0.done;
  assign o_busy = sel == 1 ? b1.busy : b0.busy;
  assign o_pass = sel == 1 ? b1.pass : b0.pass;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // f is the circuit's truth table, e the golden table; poke re-pulses start and
  // changes expected mid-sweep, abort resets the block mid-sweep
  task automatic sweep(input int w, input logic [3:0] f, input logic [3:0] e, input bit poke, input bit abort);
    int s, d, fi, last, v;
    logic [3:0] tt_e;
    bit mm;
    s = w == 1 ? 3 : 1;
    mm = f != e;
    fi = 0;
    for (int i = 3; i >= 0; i--) if (f[i] != e[i]) fi = i;
    last = (STOP && mm) ? fi : 3;
    d = (last + 1) * (s + 1) + 1;
    tt_e = f;
    if (STOP && mm) for (int i = fi + 1; i < 4; i++) tt_e[i] = 1'b0;
    @(negedge clk);
    sel = w;
    fn_r = f;
    exp_r = e;
    start_r = 1'b1;
    for (int k = 0; k <= d + 2; k++) begin
      @(posedge clk);
      #1;
      start_r = poke && k == 3;
      if (poke && k == 3) exp_r = 4'b1111;
      if (abort && k == 4) begin
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_dut_in", 32'(o_in), 0);
        chk("abort_tt", 32'(o_tt), 0);
        chk("abort_done", 32'(o_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("abort_no_done", 32'(o_done), 0);
          chk("abort_idle", 32'(o_busy), 0);
        end
        return;
      end
      v = k / (s + 1);
      chk("dut_in", 32'(o_in), 32'(v < last ? v : last));
      chk("done", 32'(o_done), 32'(k == d));
      chk("busy", 32'(o_busy), 32'(k < d));
      if (k == d) begin
        chk("tt", 32'(o_tt), 32'(tt_e));
        chk("pass", 32'(o_pass), 32'(!mm));
        chk("fail_idx", 32'(o_fi), mm ? 32'(fi) : 0);
      end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(b0.busy), 0);
    chk("rst_done0", 32'(b0.done), 0);
    chk("rst_tt0", 32'(b0.tt), 0);
    chk("rst_pass0", 32'(b0.pass), 0);
    chk("rst_in0", 32'(b0.dut_in), 0);
    chk("rst_fi0", 32'(b0.fail_idx), 0);
    chk("rst_busy1", 32'(b1.busy), 0);
    chk("rst_in1", 32'(b1.dut_in), 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 4'b0110, 4'b0110, 1'b0, 1'b0);
    sweep(0, 4'b1000, 4'b0110, 1'b0, 1'b0);
    sweep(1, 4'b0110, 4'b0110, 1'b0, 1'b0);
    sweep(0, 4'b0110, 4'b0110, 1'b1, 1'b0);
    sweep(0, 4'b0110, 4'b0110, 1'b0, 1'b1);
    sweep(0, 4'b0110, 4'b0110, 1'b0, 1'b0);
    sweep(1, 4'b1000, 4'b0110, 1'b0, 1'b0);
    for (int r = 0; r < 24; r++)
      sweep(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
